// File: rtl/wwfa_conn_ctrl.sv
// Connection controller behind the 4x4 wrapped wave-front arbiter.
// It latches accepted grants as input-to-output connections and holds each
// connection until the last beat or an idle timeout. It also drives the
// crossbar selects and reports busy outputs back to the arbiter.
module wwfa_conn_ctrl #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*N-1:0]   grant,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  input  logic [N-1:0]     out_ready,
  output logic [N-1:0]     in_ready,
  output logic [N-1:0]     out_valid,
  output logic [N*2-1:0]   out_sel,
  output logic [N-1:0]     out_blocked,
  output logic [N-1:0]     in_busy,
  output logic             timeout_evt,
  output logic             grant_err
);

  localparam int SELW = 2;
  localparam int CW   = 8;

  typedef enum logic [1:0] {S_IDLE, S_CONN, S_REL} state_t;

  state_t          state_reg [N];
  state_t          state_next[N];
  logic [SELW-1:0] sel_reg   [N];
  logic [SELW-1:0] sel_next  [N];
  logic [CW-1:0]   cnt_reg   [N];
  logic [CW-1:0]   cnt_next  [N];
  logic [N-1:0]    in_busy_reg,     in_busy_next;
  logic            timeout_evt_reg, timeout_evt_next;
  logic            grant_err_reg,   grant_err_next;

  // State registers; an asserted reset aborts every connection at once, with no pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        state_reg[j] <= S_IDLE;
        sel_reg[j]   <= '0;
        cnt_reg[j]   <= '0;
      end
      in_busy_reg     <= '0;
      timeout_evt_reg <= 1'b0;
      grant_err_reg   <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        state_reg[j] <= state_next[j];
        sel_reg[j]   <= sel_next[j];
        cnt_reg[j]   <= cnt_next[j];
      end
      in_busy_reg     <= in_busy_next;
      timeout_evt_reg <= timeout_evt_next;
      grant_err_reg   <= grant_err_next;
    end
  end

  // Next-state logic: grant acceptance (lowest output wins an input) and connection lifetime.
  always_comb begin : next_state_logic
    logic [N-1:0]    taken;
    int              ones;
    logic [SELW-1:0] src;
    logic [SELW-1:0] cur;
    logic            xfer;

    taken            = '0;
    ones             = 0;
    src              = '0;
    cur              = '0;
    xfer             = 1'b0;
    in_busy_next     = in_busy_reg;
    timeout_evt_next = 1'b0;
    grant_err_next   = grant_err_reg;
    for (int j = 0; j < N; j++) begin
      state_next[j] = state_reg[j];
      sel_next[j]   = sel_reg[j];
      cnt_next[j]   = cnt_reg[j];
    end

    for (int j = 0; j < N; j++) begin
      // Count grant bits in column j and remember the (single) source.
      ones = 0;
      src  = '0;
      for (int i = 0; i < N; i++) begin
        if (grant[i*N+j]) begin
          ones = ones + 1;
          src  = SELW'(i);
        end
      end
      cur  = sel_reg[j];
      xfer = in_valid[cur] & out_ready[j];

      case (state_reg[j])
        S_IDLE: begin
          if (ones > 1) begin
            grant_err_next = 1'b1;          // ambiguous column: drop it whole
          end else if (ones == 1) begin
            if (in_busy_reg[src] || taken[src]) begin
              grant_err_next = 1'b1;        // input owned, or already claimed by a lower output
            end else begin
              state_next[j]     = S_CONN;
              sel_next[j]       = src;
              cnt_next[j]       = '0;
              taken[src]        = 1'b1;
              in_busy_next[src] = 1'b1;
            end
          end
        end
        S_CONN: begin
          if (xfer) begin
            cnt_next[j] = '0;
            if (in_last[cur]) begin
              state_next[j]     = S_REL;
              in_busy_next[cur] = 1'b0;
            end
          end else if (cnt_reg[j] >= CW'(TIMEOUT - 1)) begin
            // Counter reaches TIMEOUT on this edge: force release.
            cnt_next[j]       = CW'(TIMEOUT);
            state_next[j]     = S_REL;
            in_busy_next[cur] = 1'b0;
            timeout_evt_next  = 1'b1;
          end else begin
            cnt_next[j] = cnt_reg[j] + 1'b1;
          end
        end
        default: begin
          state_next[j] = S_IDLE;
        end
      endcase
    end
  end

  // Per-output decode of the registered state toward the crossbar and arbiter.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign out_valid[gi]                = (state_reg[gi] == S_CONN) & in_valid[sel_reg[gi]] & out_ready[gi];
      assign out_sel[gi*SELW +: SELW]     = sel_reg[gi];
      assign out_blocked[gi]              = (state_reg[gi] != S_IDLE);
    end
  endgenerate

  // Pop strobe back to each input queue whenever its connected output takes a beat.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid[j]) in_ready[sel_reg[j]] = 1'b1;
    end
  end

  assign in_busy     = in_busy_reg;
  assign timeout_evt = timeout_evt_reg;
  assign grant_err   = grant_err_reg;

endmodule

// File: tb/tb_wwfa_conn_ctrl.sv
// Directed bench for wwfa_conn_ctrl: hand-computed expectations per cycle.
module tb_wwfa_conn_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] grant;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  out_ready;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [7:0]  out_sel;
  logic [3:0]  out_blocked;
  logic [3:0]  in_busy;
  logic        timeout_evt;
  logic        grant_err;

  int total_cnt;
  int pass_cnt;

  wwfa_conn_ctrl #(.N(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .grant       (grant),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_sel     (out_sel),
    .out_blocked (out_blocked),
    .in_busy     (in_busy),
    .timeout_evt (timeout_evt),
    .grant_err   (grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %s: got %0h expected %0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 2ns after the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    grant     = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    idle_inputs();
    reset = 1'b0;

    // Reset held low with wild grants: everything stays zero.
    step(); grant = 16'hFFFF; in_valid = 4'hF; out_ready = 4'hF; settle();
    step(); grant = 16'h1248; settle();
    chk("rst_blocked", 32'(out_blocked), 32'h0);
    chk("rst_sel",     32'(out_sel),     32'h0);
    chk("rst_valid",   32'(out_valid),   32'h0);
    chk("rst_err",     32'(grant_err),   32'h0);
    idle_inputs();
    reset = 1'b1;
    step(); settle();
    step(); settle();
    chk("post_rst_blocked", 32'(out_blocked), 32'h0);
    chk("post_rst_busy",    32'(in_busy),     32'h0);

    // Connection 1->2, three beats, last on the third.
    step(); grant = 16'h0040; in_valid = 4'b0010; out_ready = 4'b0100; settle();
    chk("c12_c0_blocked", 32'(out_blocked[2]), 32'h0);
    step(); grant = '0; settle();
    chk("c12_c1_blocked", 32'(out_blocked[2]), 32'h1);
    chk("c12_c1_sel",     32'(out_sel[5:4]),   32'h1);
    chk("c12_c1_ovalid",  32'(out_valid),      32'b0100);
    chk("c12_c1_iready",  32'(in_ready),       32'b0010);
    chk("c12_c1_busy",    32'(in_busy),        32'b0010);
    step(); settle();
    chk("c12_c2_ovalid",  32'(out_valid),      32'b0100);
    step(); in_last = 4'b0010; settle();
    chk("c12_c3_iready",  32'(in_ready),       32'b0010);
    step(); in_last = '0; settle();
    chk("c12_c4_ovalid",  32'(out_valid),      32'h0);
    chk("c12_c4_blocked", 32'(out_blocked[2]), 32'h1);
    chk("c12_c4_busy",    32'(in_busy),        32'h0);
    step(); settle();
    chk("c12_c5_blocked", 32'(out_blocked[2]), 32'h0);

    // Connection 0->3 with no data: timeout after 16 idle cycles.
    idle_inputs();
    step(); grant = 16'h0008; out_ready = 4'b1000; settle();
    step(); grant = '0; settle();
    chk("to_c1_blocked", 32'(out_blocked[3]), 32'h1);
    for (int k = 2; k <= 16; k++) begin
      step(); settle();
    end
    chk("to_c16_evt",     32'(timeout_evt),    32'h0);
    chk("to_c16_blocked", 32'(out_blocked[3]), 32'h1);
    step(); settle();
    chk("to_c17_evt",     32'(timeout_evt),    32'h1);
    chk("to_c17_blocked", 32'(out_blocked[3]), 32'h1);
    step(); settle();
    chk("to_c18_evt",     32'(timeout_evt),    32'h0);
    chk("to_c18_blocked", 32'(out_blocked[3]), 32'h0);
    chk("to_err",         32'(grant_err),      32'h0);

    // Two inputs granted to column 1: dropped, sticky error.
    step(); grant = 16'h0202; settle();
    step(); grant = '0; settle();
    chk("dup_blocked", 32'(out_blocked), 32'h0);
    chk("dup_busy",    32'(in_busy),     32'h0);
    chk("dup_err",     32'(grant_err),   32'h1);
    step(); step(); step(); settle();
    chk("dup_err_sticky", 32'(grant_err), 32'h1);

    // Input 3 granted to outputs 0 and 1: output 0 wins; single-beat packet.
    do_reset();
    step(); grant = 16'h3000; in_valid = 4'b1000; in_last = 4'b1000; out_ready = 4'b0001; settle();
    chk("two_err_pre", 32'(grant_err), 32'h0);
    step(); grant = '0; settle();
    chk("two_blocked", 32'(out_blocked), 32'b0001);
    chk("two_sel0",    32'(out_sel[1:0]), 32'h3);
    chk("two_err",     32'(grant_err),    32'h1);
    chk("two_ovalid",  32'(out_valid),    32'b0001);
    step(); settle();
    chk("one_beat_rel_ovalid",  32'(out_valid),   32'h0);
    chk("one_beat_rel_blocked", 32'(out_blocked), 32'b0001);
    step(); settle();
    chk("one_beat_idle",        32'(out_blocked), 32'h0);

    // Back-pressure then asynchronous mid-packet reset on 2->1.
    do_reset();
    idle_inputs();
    step(); grant = 16'h0200; in_valid = 4'b0100; settle();
    step(); grant = '0; settle();
    chk("bp_ovalid",  32'(out_valid),   32'h0);
    chk("bp_blocked", 32'(out_blocked), 32'b0010);
    out_ready = 4'b0010; settle();
    chk("bp_release_ovalid", 32'(out_valid), 32'b0010);
    #2; reset = 1'b0; #1;
    chk("arst_blocked", 32'(out_blocked), 32'h0);
    chk("arst_ovalid",  32'(out_valid),   32'h0);
    chk("arst_busy",    32'(in_busy),     32'h0);
    #3; reset = 1'b1;
    step(); grant = 16'h0200; settle();
    step(); grant = '0; settle();
    chk("reconn_blocked", 32'(out_blocked), 32'b0010);
    chk("reconn_sel1",    32'(out_sel[3:2]), 32'h2);
    chk("reconn_ovalid",  32'(out_valid),    32'b0010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wwfa_conn_ctrl.md
Name: wwfa_conn_ctrl

Overview:
- Connection controller directly downstream of the 4x4 wrapped wave-front arbiter array.
- Each cycle it samples the arbiter grant matrix and latches accepted grants as input-to-output connections.
- It holds each connection until end of packet, or until an idle timeout, and drives the crossbar select lines.
- It feeds per-output out_blocked back to the arbiter points, so busy outputs are excluded from new arbitration.

Parameters:
- N, 4, number of input and output ports; SELW = 2 fixed for N = 4.
- TIMEOUT, 16, idle cycles allowed on an open connection before forced release; legal range 2..255.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- grant  input  N*N  arbiter result matrix; bit i*N+j = input i granted to output j; sampled every cycle.
- in_valid  input  N  per-input beat valid.
- in_last  input  N  per-input last beat of packet; qualified by in_valid.
- out_ready  input  N  per-output downstream ready.
- in_ready  output  N  per-input pop strobe to the input queue.
- out_valid  output  N  per-output beat valid toward the crossbar.
- out_sel  output  N*2  per-output source input index; bits 2j+1:2j belong to output j.
- out_blocked  output  N  per-output busy flag to the arbiter; 1 = output owned or releasing.
- in_busy  output  N  per-input flag; 1 = input owns an output.
- timeout_evt  output  1  one-cycle pulse on any forced release.
- grant_err  output  1  sticky error; cleared only by reset.

Behaviour:
- Reset (reset = 0, asynchronous): all per-output FSMs go to IDLE, all counters 0, every output port 0.
- Per-output FSM, states IDLE, CONN, REL.
- IDLE -> CONN when column j of grant has exactly one bit set (input i), input i is not in_busy, and no lower-indexed output j' < j accepts input i in the same cycle.
  - On this transition: out_sel[j] <= i, out_blocked[j] <= 1, in_busy[i] <= 1.
  - Grant-to-connection latency is 1 cycle; the first transfer is possible in the cycle after the grant.
- CONN, transfer condition: in_valid[i] & out_ready[j].
  - in_ready[i] and out_valid[j] are combinational from the registered state: both = in_valid[i] & out_ready[j] while CONN, else 0.
  - The idle counter resets to 0 on each transfer, else increments, saturating at TIMEOUT.
- CONN -> REL:
  - on a transfer with in_last[i] = 1; or
  - when the idle counter reaches TIMEOUT (pulse timeout_evt; no transfer that cycle).
- REL -> IDLE after exactly 1 cycle.
  - out_blocked[j] stays 1 during REL and drops on entry to IDLE.
  - in_busy[i] clears on entry to REL, so input i may be granted a different output in the REL cycle.
- Grants seen while an output is in CONN or REL are ignored silently; the arbiter should not produce them, since out_blocked is 1.
- Illegal grant patterns, checked every cycle; each sets grant_err and the offending grant is dropped:
  - more than one bit set in an IDLE column → the whole column is dropped that cycle;
  - grant to an input that is already in_busy;
  - two IDLE outputs granting the same free input → lowest j wins, the others are dropped and grant_err is set.
- A single-beat packet (in_last with the first transfer) gives CONN for 1 cycle, then REL.
- Back-pressure: out_ready = 0 holds the state, and the idle counter still counts.
- Timeout and a last-beat transfer cannot coincide, since a transfer resets the counter.
- Reset asserted mid-packet aborts all connections immediately with no pulses.

Test Plan:
- Reset held low, drive random grant → all outputs 0, out_sel all 0; release reset with grant = 0 → outputs stay 0.
- grant bit 1*4+2 for one cycle, in_valid[1] = 1, out_ready[2] = 1, in_last on 3rd beat:
  - out_blocked[2] = 1 from cycle +1;
  - out_sel[2] = 1;
  - out_valid[2] = in_ready[1] = 1 for 3 cycles;
  - REL 1 cycle;
  - out_blocked[2] = 0 at cycle +5.
- Connection 0->3 with in_valid[0] = 0 and TIMEOUT = 16 → timeout_evt pulses at cycle 16 after connect, out_blocked[3] clears 1 cycle later, grant_err = 0.
- Column 1 with grant bits from inputs 0 and 2 simultaneously → no connection, grant_err = 1 and remains 1 until reset.
- Grants 3->0 and 3->1 in the same cycle, both outputs IDLE → only output 0 connects (out_sel[0] = 3); output 1 stays IDLE; grant_err = 1.
- Connection 2->1 mid-packet, pulse reset low for half a cycle asynchronously → all outputs 0 immediately; after release a new grant 2->1 connects normally.
